// File: rtl/mem_wb_stage.sv
// MEM stage of the 5-stage MIPS core: data-memory access with byte/halfword lanes,
// followed by the MEM/WB pipeline register with stall and flush control.
module mem_wb_stage #(
    parameter int unsigned ADDR_BITS = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_PC,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_ALUout,
    input  logic [31:0] in_data_rt,
    input  logic [31:0] in_addr_rd,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] out_PC,
    output logic [31:0] out_instruction,
    output logic [31:0] out_ALUout,
    output logic [31:0] out_mem_data,
    output logic [31:0] out_addr_rd,
    output logic        out_addr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    typedef enum logic [3:0] {
        ACC_NONE,
        ACC_LW,
        ACC_LB,
        ACC_LBU,
        ACC_LH,
        ACC_LHU,
        ACC_SW,
        ACC_SB,
        ACC_SH
    } access_e;

    logic [31:0]          mem [DEPTH];

    access_e              acc;
    logic [31:0]          off;
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane;
    logic                 in_range;
    logic                 aligned;
    logic                 is_load;
    logic                 is_store;
    logic                 access_ok;
    logic                 addr_err;
    logic [31:0]          rd_word;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [31:0]          load_data;
    logic [31:0]          wr_word;
    logic                 wr_en;

    always_comb begin
        acc = ACC_NONE;
        unique case (in_instruction[31:26])
            6'h23:   acc = ACC_LW;
            6'h20:   acc = ACC_LB;
            6'h24:   acc = ACC_LBU;
            6'h21:   acc = ACC_LH;
            6'h25:   acc = ACC_LHU;
            6'h2b:   acc = ACC_SW;
            6'h28:   acc = ACC_SB;
            6'h29:   acc = ACC_SH;
            default: acc = ACC_NONE;
        endcase
    end

    assign off      = in_ALUout - BASE_ADDR;
    assign word_idx = off[ADDR_BITS+1:2];
    assign lane     = off[1:0];
    assign in_range = (off[31:ADDR_BITS+2] == '0);

    assign is_load  = (acc == ACC_LW) || (acc == ACC_LB) || (acc == ACC_LBU) ||
                      (acc == ACC_LH) || (acc == ACC_LHU);
    assign is_store = (acc == ACC_SW) || (acc == ACC_SB) || (acc == ACC_SH);

    always_comb begin
        aligned = 1'b1;
        case (acc)
            ACC_LW, ACC_SW:          aligned = (lane == 2'b00);
            ACC_LH, ACC_LHU, ACC_SH: aligned = ~lane[0];
            default:                 aligned = 1'b1;
        endcase
    end

    assign access_ok = in_range && aligned;
    assign addr_err  = (is_load || is_store) && !access_ok;

    // Read port sees the array as written on the previous edge, giving store-to-load RAW.
    assign rd_word = mem[word_idx];

    always_comb begin
        ld_byte = rd_word[7:0];
        case (lane)
            2'd0: ld_byte = rd_word[7:0];
            2'd1: ld_byte = rd_word[15:8];
            2'd2: ld_byte = rd_word[23:16];
            2'd3: ld_byte = rd_word[31:24];
            default: ld_byte = rd_word[7:0];
        endcase
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        load_data = '0;
        if (access_ok) begin
            case (acc)
                ACC_LW:  load_data = rd_word;
                ACC_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
                ACC_LBU: load_data = {24'h0, ld_byte};
                ACC_LH:  load_data = {{16{ld_half[15]}}, ld_half};
                ACC_LHU: load_data = {16'h0, ld_half};
                default: load_data = '0;
            endcase
        end
    end

    always_comb begin
        wr_word = rd_word;
        case (acc)
            ACC_SW: wr_word = in_data_rt;
            ACC_SH: begin
                if (lane[1]) wr_word[31:16] = in_data_rt[15:0];
                else         wr_word[15:0]  = in_data_rt[15:0];
            end
            ACC_SB: begin
                case (lane)
                    2'd0: wr_word[7:0]   = in_data_rt[7:0];
                    2'd1: wr_word[15:8]  = in_data_rt[7:0];
                    2'd2: wr_word[23:16] = in_data_rt[7:0];
                    2'd3: wr_word[31:24] = in_data_rt[7:0];
                    default: wr_word = rd_word;
                endcase
            end
            default: wr_word = rd_word;
        endcase
    end

    // A flushed store still commits; only stall suppresses the write.
    assign wr_en = is_store && access_ok && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[word_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_PC          <= '0;
            out_instruction <= '0;
            out_ALUout      <= '0;
            out_mem_data    <= '0;
            out_addr_rd     <= '0;
            out_addr_err    <= 1'b0;
        end else if (stall) begin
            out_PC          <= out_PC;
            out_instruction <= out_instruction;
            out_ALUout      <= out_ALUout;
            out_mem_data    <= out_mem_data;
            out_addr_rd     <= out_addr_rd;
            out_addr_err    <= out_addr_err;
        end else if (flush) begin
            out_PC          <= '0;
            out_instruction <= '0;
            out_ALUout      <= '0;
            out_mem_data    <= '0;
            out_addr_rd     <= '0;
            out_addr_err    <= 1'b0;
        end else begin
            out_PC          <= in_PC;
            out_instruction <= in_instruction;
            out_ALUout      <= in_ALUout;
            out_mem_data    <= load_data;
            out_addr_rd     <= in_addr_rd;
            out_addr_err    <= addr_err;
        end
    end

endmodule
